// File: rtl/sram_arb_pkg.sv
// Shared types and default geometry for the SRAM read/write arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package sram_arb_pkg;

  localparam int DEPTH_DEF = 1024;
  localparam int WIDTH_DEF = 328;
  localparam int SEGS_DEF  = 4;

  // Response-path / sweep state of the arbiter.
  typedef enum logic [1:0] {
    INIT = 2'd0,  // post-reset zero-fill sweep
    IDLE = 2'd1,  // no read response outstanding
    RD   = 2'd2,  // response presented straight from the macro
    HOLD = 2'd3   // response presented from the hold register
  } state_t;

  // Which requester won the most recent conflict.
  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } side_t;

endpackage

// File: rtl/sram_arb_rr.sv
// 2-way round-robin picker: on a conflict it grants the side that lost last time.
// Latency: grants are combinational; only rr_last is registered.
// Backpressure: a non-eligible side is never granted; a lone eligible side always is.
// Ports: clock/reset, rd_elig/wr_elig (valid and allowed), rd_gnt/wr_gnt (one-hot or zero).
module sram_arb_rr
  import sram_arb_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic rd_elig,
  input  logic wr_elig,
  output logic rd_gnt,
  output logic wr_gnt
);

  side_t rr_last;
  logic  conflict;

  always_comb begin
    conflict = rd_elig & wr_elig;
    rd_gnt   = rd_elig & (~wr_elig | (rr_last == WRITE));
    wr_gnt   = wr_elig & (~rd_elig | (rr_last == READ));
  end

  // Starts at WRITE so the first conflict after reset goes to the reader.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_last <= WRITE;
    end else if (conflict) begin
      rr_last <= rd_gnt ? READ : WRITE;
    end
  end

endmodule

// File: rtl/sram_rw_arbiter.sv
// Shares one masked RW SRAM port between a reader and a writer, zero-fills the array after reset.
// Latency: read data one cycle after the read grant; writes issue in the grant cycle.
// Backpressure: a stalled response moves to a hold register and blocks new reads; writes still flow.
// Ports: rd_req_*/rd_resp_* read handshake, wr_req_* write handshake, init_done, sram_* to the macro.
// Optional: define SRAM_ARB_PERF_EN to add perf_rd_cnt / perf_wr_cnt / perf_conflict_cnt.
module sram_rw_arbiter
  import sram_arb_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int SEGS  = SEGS_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rd_req_valid,
  output logic             rd_req_ready,
  input  logic [AW-1:0]    rd_req_addr,
  output logic             rd_resp_valid,
  input  logic             rd_resp_ready,
  output logic [WIDTH-1:0] rd_resp_data,
  input  logic             wr_req_valid,
  output logic             wr_req_ready,
  input  logic [AW-1:0]    wr_req_addr,
  input  logic [SEGS-1:0]  wr_req_mask,
  input  logic [WIDTH-1:0] wr_req_data,
  output logic             init_done,
  output logic             sram_en,
  output logic             sram_wmode,
  output logic [AW-1:0]    sram_addr,
  output logic [SEGS-1:0]  sram_wmask,
  output logic [WIDTH-1:0] sram_wdata,
  input  logic [WIDTH-1:0] sram_rdata
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [31:0]      perf_rd_cnt,
  output logic [31:0]      perf_wr_cnt,
  output logic [31:0]      perf_conflict_cnt
`endif
);

  state_t           state, state_nxt;
  logic [AW-1:0]    init_cnt;
  logic [WIDTH-1:0] hold_dat;
  logic             rd_elig, wr_elig, rd_gnt, wr_gnt;

  // A new read may issue only if the slot is free or is being drained this cycle.
  // Everything is masked during the reset cycle so nothing reaches the macro.
  assign rd_elig = rd_req_valid & ~reset &
                   ((state == IDLE) | ((state == RD) & rd_resp_ready));
  assign wr_elig = wr_req_valid & ~reset & (state != INIT);

  sram_arb_rr u_rr (
    .clock   (clock),
    .reset   (reset),
    .rd_elig (rd_elig),
    .wr_elig (wr_elig),
    .rd_gnt  (rd_gnt),
    .wr_gnt  (wr_gnt)
  );

  assign rd_req_ready  = rd_gnt;
  assign wr_req_ready  = wr_gnt;
  assign rd_resp_valid = (state == RD) | (state == HOLD);
  assign rd_resp_data  = (state == HOLD) ? hold_dat : sram_rdata;

  always_comb begin
    state_nxt  = state;
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = wr_req_addr;
    sram_wmask = wr_req_mask;
    sram_wdata = wr_req_data;

    if (state == INIT) begin
      sram_en    = ~reset;
      sram_wmode = 1'b1;
      sram_addr  = init_cnt;
      sram_wmask = '1;
      sram_wdata = '0;
    end else if (rd_gnt) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b0;
      sram_addr  = rd_req_addr;
    end else if (wr_gnt) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
    end

    case (state)
      INIT:    if (init_cnt == AW'(DEPTH - 1)) state_nxt = IDLE;
      IDLE:    if (rd_gnt) state_nxt = RD;
      RD:      if (rd_resp_ready) state_nxt = rd_gnt ? RD : IDLE;
               else               state_nxt = HOLD;
      HOLD:    if (rd_resp_ready) state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
      hold_dat  <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) begin
        init_cnt <= init_cnt + AW'(1);
        if (init_cnt == AW'(DEPTH - 1)) init_done <= 1'b1;
      end
      // The macro output is only valid for one cycle; park it when the consumer stalls.
      if ((state == RD) && !rd_resp_ready) hold_dat <= sram_rdata;
    end
  end

`ifdef SRAM_ARB_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_rd_cnt       <= '0;
      perf_wr_cnt       <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (rd_gnt)             perf_rd_cnt       <= perf_rd_cnt + 32'd1;
      if (wr_gnt)             perf_wr_cnt       <= perf_wr_cnt + 32'd1;
      if (rd_elig && wr_elig) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule
